// File: rtl/regfile_dump.sv
// regfile_dump: parametrised register file with optional zero register,
// optional write-to-read bypass, asynchronous clear and a handshaked
// dump port that streams every register out in address order.

// One combinational read port. A port with BYPASS=0 and wr_en tied low
// gives a plain stored-value view; the dump path uses it that way.
module regfile_dump_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rdata
);
  // Priority: hardwired zero beats bypass beats stored value.
  always_comb begin
    rdata = mem[addr];
    if (BYPASS != 0 && wr_en && wr_addr == addr) rdata = wr_data;
    if (ZERO_REG != 0 && addr == '0)             rdata = '0;
  end
endmodule

module regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  wr_req_t                       wr;
  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             idx_q, idx_d;

  assign wr = '{en: reg_write, addr: write_register, data: write_data};

  // Storage: async clear, register 0 write-protected when hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem <= '0;
    else if (wr.en && !(ZERO_REG != 0 && wr.addr == '0))
      mem[wr.addr] <= wr.data;
  end

  assign rd_addr[0]  = read_register_1;
  assign rd_addr[1]  = read_register_2;
  assign read_data_1 = rd_data[0];
  assign read_data_2 = rd_data[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_dump_rd #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .mem    (mem),
      .addr   (rd_addr[p]),
      .wr_en  (wr.en),
      .wr_addr(wr.addr),
      .wr_data(wr.data),
      .rdata  (rd_data[p])
    );
  end

  // Dump view never bypasses: the beat reports what is stored at the
  // accepting edge, so a same-edge write to idx shows the old value.
  regfile_dump_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(0)
  ) u_dump_rd (
    .mem    (mem),
    .addr   (idx_q),
    .wr_en  (1'b0),
    .wr_addr('0),
    .wr_data('0),
    .rdata  (dump_data)
  );

  // Dump FSM state and index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: start only from IDLE, advance on each accepted beat,
  // drop back to IDLE with idx cleared after the last register.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == '1) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign dump_addr = idx_q;
  assign dump_busy = dump_valid;
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (zero-reg+bypass, and plain)
// share stimulus; a register-array model is checked every cycle, and
// directed literal expectations pin the model.
module tb_regfile_dump;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register_1, read_register_2;
  logic        dump_start, dump_ready;

  logic [31:0] rd1_a, rd2_a, dd_a, rd1_b, rd2_b, dd_b;
  logic [4:0]  da_a, da_b;
  logic        dv_a, db_a, dv_b, db_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 0;

  typedef struct { int addr; logic [31:0] data; } beat_t;
  beat_t acc_q[$];

  // model state
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          m_stream;
  int          m_idx;

  always #5 clk = ~clk;

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .read_register_1(read_register_1),
    .read_register_2(read_register_2), .read_data_1(rd1_a), .read_data_2(rd2_a),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dv_a),
    .dump_addr(da_a), .dump_data(dd_a), .dump_busy(db_a));

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .read_register_1(read_register_1),
    .read_register_2(read_register_2), .read_data_1(rd1_b), .read_data_2(rd2_b),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dv_b),
    .dump_addr(da_b), .dump_data(dd_b), .dump_busy(db_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Model: registers as arrays; a dump is "streaming at index m_idx".
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin ma[i] <= '0; mb[i] <= '0; end
      m_stream <= 0;
      m_idx    <= 0;
    end else begin
      if (m_stream) begin
        if (dump_ready) begin
          if (m_idx == 31) begin m_stream <= 0; m_idx <= 0; end
          else m_idx <= m_idx + 1;
        end
      end else if (dump_start) begin
        m_stream <= 1;
        m_idx    <= 0;
      end
      if (reg_write) begin
        if (write_register != 0) ma[write_register] <= write_data;
        mb[write_register] <= write_data;
      end
    end
  end

  function automatic logic [31:0] exp_rd_a(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (reg_write && write_register == a) return write_data;
    return ma[a];
  endfunction

  // Per-cycle comparison against the model, plus capture of accepted beats.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_rd1", rd1_a, exp_rd_a(read_register_1));
      chk("a_rd2", rd2_a, exp_rd_a(read_register_2));
      chk("b_rd1", rd1_b, mb[read_register_1]);
      chk("b_rd2", rd2_b, mb[read_register_2]);
      chk("a_dv", {31'b0, dv_a}, {31'b0, m_stream});
      chk("b_dv", {31'b0, dv_b}, {31'b0, m_stream});
      chk("a_busy", {31'b0, db_a}, {31'b0, m_stream});
      chk("b_busy", {31'b0, db_b}, {31'b0, m_stream});
      chk("a_daddr", {27'b0, da_a}, m_idx);
      chk("b_daddr", {27'b0, da_b}, m_idx);
      chk("a_ddata", dd_a, (m_idx == 0) ? 32'h0 : ma[m_idx]);
      chk("b_ddata", dd_b, mb[m_idx]);
      if (dv_a && dump_ready) acc_q.push_back('{addr: int'(da_a), data: dd_a});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1; reg_write = 0; write_register = 0; write_data = 0;
    read_register_1 = 0; read_register_2 = 0; dump_start = 0; dump_ready = 0;
    tick(); tick();
    chk("rst_dv", {31'b0, dv_a}, 0);
    chk("rst_busy", {31'b0, db_a}, 0);
    chk("rst_daddr", {27'b0, da_a}, 0);
    chk("rst_ddata", dd_a, 0);
    chk("rst_rd1", rd1_b, 0);
    rst = 0;
    chk_en = 1;

    // write r5 then asynchronous clear mid-cycle
    reg_write = 1; write_register = 5; write_data = 32'hDEADBEEF; read_register_1 = 5;
    tick();
    reg_write = 0;
    chk("r5_written_a", rd1_a, 32'hDEADBEEF);
    chk("r5_written_b", rd1_b, 32'hDEADBEEF);
    #1 rst = 1;
    #1;
    chk("async_clr_a", rd1_a, 0);
    chk("async_clr_b", rd1_b, 0);
    chk("async_clr_dv", {31'b0, dv_a}, 0);
    #1 rst = 0;
    tick();

    // zero register
    reg_write = 1; write_register = 0; write_data = 32'h1234; read_register_1 = 0;
    #1;
    chk("r0_zero_a", rd1_a, 0);
    chk("r0_nobyp_b", rd1_b, 0);
    tick();
    reg_write = 0;
    chk("r0_after_a", rd1_a, 0);
    chk("r0_after_b", rd1_b, 32'h1234);

    // bypass
    reg_write = 1; write_register = 7; write_data = 32'hA5A5A5A5;
    read_register_1 = 7; read_register_2 = 7;
    #1;
    chk("byp_rd1_a", rd1_a, 32'hA5A5A5A5);
    chk("byp_rd2_a", rd2_a, 32'hA5A5A5A5);
    chk("nobyp_rd1_b", rd1_b, 0);
    chk("nobyp_rd2_b", rd2_b, 0);
    tick();
    reg_write = 0;
    chk("nobyp_after_b", rd1_b, 32'hA5A5A5A5);

    // preload rK = K*0x11
    for (int k = 0; k < 32; k++) begin
      reg_write = 1; write_register = k[4:0]; write_data = k * 32'h11;
      tick();
    end
    reg_write = 0;

    // full dump with a stray dump_start mid-stream
    acc_q.delete();
    dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    chk("dump_first_dv", {31'b0, dv_a}, 1);
    chk("dump_first_addr", {27'b0, da_a}, 0);
    for (int c = 0; c < 34; c++) begin
      dump_start = (c == 10);
      tick();
    end
    dump_start = 0;
    chk("dump_done_dv", {31'b0, dv_a}, 0);
    chk("dump_beats", acc_q.size(), 32);
    for (int k = 0; k < 32 && k < acc_q.size(); k++) begin
      chk("dump_addr_k", acc_q[k].addr, k);
      chk("dump_data_k", acc_q[k].data, k * 32'h11);
    end

    // back-pressure: ready 1,0,0,1 with a write to the stalled register
    acc_q.delete();
    dump_ready = 0; dump_start = 1;
    tick();
    dump_start = 0;
    dump_ready = 1;
    tick();
    dump_ready = 0;
    chk("bp_addr1", {27'b0, da_a}, 1);
    reg_write = 1; write_register = 1; write_data = 32'h99;
    tick();
    reg_write = 0;
    chk("bp_hold_addr", {27'b0, da_a}, 1);
    chk("bp_live_data", dd_a, 32'h99);
    tick();
    chk("bp_hold_addr2", {27'b0, da_a}, 1);
    dump_ready = 1;
    tick();
    chk("bp_adv_addr", {27'b0, da_a}, 2);
    reg_write = 1; write_register = 2; write_data = 32'h77;
    tick();
    reg_write = 0;
    chk("bp_acc_n", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      chk("bp_acc1_addr", acc_q[1].addr, 1);
      chk("bp_acc1_data", acc_q[1].data, 32'h99);
      chk("bp_acc2_data", acc_q[2].data, 32'h22);
    end

    // reset mid-dump at beat 10
    n = 0;
    while (da_a != 5'd10 && n < 40) begin tick(); n++; end
    chk("reach_beat10", {27'b0, da_a}, 10);
    #1 rst = 1;
    #1;
    chk("mid_rst_dv_a", {31'b0, dv_a}, 0);
    chk("mid_rst_dv_b", {31'b0, dv_b}, 0);
    chk("mid_rst_busy", {31'b0, db_a}, 0);
    chk("mid_rst_addr", {27'b0, da_a}, 0);
    @(posedge clk);
    #1 rst = 0;
    acc_q.delete();

    // restart after reset: all zero data
    dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    repeat (34) tick();
    chk("rs_beats", acc_q.size(), 32);
    for (int k = 0; k < 32 && k < acc_q.size(); k++) begin
      chk("rs_addr_k", acc_q[k].addr, k);
      chk("rs_data_k", acc_q[k].data, 0);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
